// File: rtl/apb_uart_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_uart_if                                                  |
// | Description : Peripheral-bus signal bundle for apb_uart (master/slave).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface apb_uart_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [3:0]            pstb;
  logic                  ready;
  logic                  perr;

  modport master (
    output paddr, pdata, psel, penable, pwrite, pstb,
    input  prdata, ready, perr
  );

  modport slave (
    input  paddr, pdata, psel, penable, pwrite, pstb,
    output prdata, ready, perr
  );
endinterface
`default_nettype wire

// File: rtl/apb_uart.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_uart                                                     |
// | Description : Bus-slave UART, buffered 8N1 transmitter with programmable   |
// |               baud divisor. Define UART_RX_EN to add the receiver with a   |
// |               1-byte holding register.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module apb_uart #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  wire logic pclk,
  input  wire logic rst,
  apb_uart_if.slave bus,
  output logic      tx,
  input  wire logic rx
);
  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);
  localparam logic [1:0] c_TX_IDLE = 2'd0, c_TX_START = 2'd1, c_TX_DATA = 2'd2, c_TX_STOP = 2'd3;

  logic                  r_ready, r_perr;
  logic [DATA_WIDTH-1:0] r_prdata, w_stat_word, w_div_word;
  logic [15:0]           r_div;
  logic                  w_access, w_full, w_empty, w_push, w_pop, w_busy, w_bit_done;
  logic [1:0]            w_reg;
  logic [7:0]            r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]       r_wptr, r_rptr;
  logic [c_CW-1:0]       r_count;
  logic [31:0]           w_cnt32;
  logic [7:0]            w_txcnt;
  logic [2:0]            w_rx_flags;
  logic [1:0]            r_tx_state, w_tx_next;
  logic [15:0]           r_tx_cnt, r_tx_div;
  logic [2:0]            r_tx_bit;
  logic [7:0]            r_tx_shift;
  logic [ADDR_WIDTH+DATA_WIDTH-17:0] w_unused_bus;

  // Address bits outside [3:2], upper data bits and upper strobes are don't-care.
  assign w_unused_bus = {bus.paddr[ADDR_WIDTH-1:4], bus.paddr[1:0],
                         bus.pdata[DATA_WIDTH-1:16], bus.pstb[3:2]};

  assign w_access = bus.psel & bus.penable & ~r_ready;
  assign w_reg    = bus.paddr[3:2];
  assign w_full   = (r_count == c_FULL);
  assign w_empty  = (r_count == '0);
  // Full check uses the pre-pop count: a full FIFO rejects even if it pops this cycle.
  assign w_push   = w_access & bus.pwrite & (w_reg == 2'd0) & bus.pstb[0] & ~w_full;
  assign w_cnt32  = 32'(r_count);
  assign w_txcnt  = (w_cnt32 > 32'd255) ? 8'hFF : w_cnt32[7:0];

  assign bus.ready  = r_ready;
  assign bus.perr   = r_perr;
  assign bus.prdata = r_prdata;

  // Status and divisor read words, zero-extended to the bus width.
  always_comb begin
    w_stat_word       = '0;
    w_stat_word[15:0] = {w_txcnt, 2'b00, w_rx_flags, w_busy, w_empty, w_full};
    w_div_word        = '0;
    w_div_word[15:0]  = r_div;
  end

`ifdef UART_RX_EN
  localparam logic [1:0] c_RX_IDLE = 2'd0, c_RX_START = 2'd1, c_RX_DATA = 2'd2, c_RX_STOP = 2'd3;
  logic                  r_rx_s1, r_rx_s2, r_rx_prev;
  logic [1:0]            r_rx_state, w_rx_next;
  logic [15:0]           r_rx_cnt;
  logic [2:0]            r_rx_bit;
  logic [7:0]            r_rx_shift, r_rx_byte;
  logic                  r_rx_valid, r_rx_ovr, r_rx_ferr;
  logic                  w_rx_half, w_rx_end, w_rx_take, w_rx_good, w_rx_bad;
  logic                  w_rd_data, w_clr_ovr, w_clr_ferr;
  logic [DATA_WIDTH-1:0] w_rx_word;

  assign w_rx_flags = {r_rx_ferr, r_rx_ovr, r_rx_valid};
  assign w_rx_half  = (r_rx_cnt == (r_div >> 1));
  assign w_rx_end   = (r_rx_cnt == r_div);
  assign w_rd_data  = w_access & ~bus.pwrite & (w_reg == 2'd0);
  assign w_clr_ovr  = w_access & bus.pwrite & (w_reg == 2'd1) & bus.pstb[0] & bus.pdata[4];
  assign w_clr_ferr = w_access & bus.pwrite & (w_reg == 2'd1) & bus.pstb[0] & bus.pdata[5];

  // Holding-register read word: zero when nothing has been received.
  always_comb begin
    w_rx_word = '0;
    if (r_rx_valid) w_rx_word[7:0] = r_rx_byte;
  end

  // RX state register.
  always_ff @(posedge pclk) begin
    if (rst) r_rx_state <= c_RX_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  // RX next state: start on a falling edge, abort if the start bit is not low at mid-bit.
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      c_RX_IDLE:  if (r_rx_prev & ~r_rx_s2) w_rx_next = c_RX_START;
      c_RX_START: if (w_rx_half & r_rx_s2) w_rx_next = c_RX_IDLE;
                  else if (w_rx_end) w_rx_next = c_RX_DATA;
      c_RX_DATA:  if (w_rx_end && r_rx_bit == 3'd7) w_rx_next = c_RX_STOP;
      default:    if (w_rx_half) w_rx_next = c_RX_IDLE;
    endcase
  end

  // RX outputs: mid-bit sample strobes and stop-bit verdict.
  always_comb begin
    w_rx_take = (r_rx_state == c_RX_DATA) & w_rx_half;
    w_rx_good = (r_rx_state == c_RX_STOP) & w_rx_half & r_rx_s2;
    w_rx_bad  = (r_rx_state == c_RX_STOP) & w_rx_half & ~r_rx_s2;
  end

  // RX datapath: synchroniser, bit timer, shifter, holding register and sticky flags.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_prev <= 1'b1;
      r_rx_cnt <= '0; r_rx_bit <= '0; r_rx_shift <= '0; r_rx_byte <= '0;
      r_rx_valid <= 1'b0; r_rx_ovr <= 1'b0; r_rx_ferr <= 1'b0;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      r_rx_cnt  <= (r_rx_state == c_RX_IDLE || w_rx_end) ? 16'd0 : r_rx_cnt + 16'd1;
      if (r_rx_state == c_RX_IDLE) r_rx_bit <= '0;
      else if (r_rx_state == c_RX_DATA && w_rx_end) r_rx_bit <= r_rx_bit + 3'd1;
      if (w_rx_take) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
      if (w_rd_data)  r_rx_valid <= 1'b0;
      if (w_clr_ovr)  r_rx_ovr   <= 1'b0;
      if (w_clr_ferr) r_rx_ferr  <= 1'b0;
      // A new byte wins over a same-cycle read; overrun only if the old byte was never read.
      if (w_rx_good) begin
        r_rx_byte  <= r_rx_shift;
        r_rx_valid <= 1'b1;
        if (r_rx_valid && !w_rd_data) r_rx_ovr <= 1'b1;
      end
      if (w_rx_bad) r_rx_ferr <= 1'b1;
    end
  end
`else
  logic w_unused_rx;
  assign w_unused_rx = rx;
  assign w_rx_flags  = 3'b000;
`endif

  // Bus slave: one wait state, registered response, divisor register.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_ready <= 1'b0; r_perr <= 1'b0; r_prdata <= '0; r_div <= DEFAULT_DIV;
    end else begin
      r_ready  <= w_access;
      r_perr   <= 1'b0;
      r_prdata <= '0;
      if (w_access) begin
        case (w_reg)
          2'd0: begin
            if (bus.pwrite) r_perr <= bus.pstb[0] & w_full;
            else begin
`ifdef UART_RX_EN
              r_prdata <= w_rx_word;
`else
              r_perr <= 1'b1;
`endif
            end
          end
          2'd1: if (!bus.pwrite) r_prdata <= w_stat_word;
          2'd2: begin
            if (bus.pwrite) begin
              if (bus.pstb[0]) r_div[7:0]  <= bus.pdata[7:0];
              if (bus.pstb[1]) r_div[15:8] <= bus.pdata[15:8];
            end else r_prdata <= w_div_word;
          end
          default: r_perr <= 1'b1;
        endcase
      end
    end
  end

  // TX FIFO storage, no reset needed.
  always_ff @(posedge pclk) begin
    if (w_push) r_mem[r_wptr] <= bus.pdata[7:0];
  end

  // TX FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_wptr <= '0; r_rptr <= '0; r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // TX state register.
  always_ff @(posedge pclk) begin
    if (rst) r_tx_state <= c_TX_IDLE;
    else     r_tx_state <= w_tx_next;
  end

  // TX next state; a pop happens on every entry to START, including STOP->START.
  always_comb begin
    w_tx_next  = r_tx_state;
    w_pop      = 1'b0;
    w_bit_done = (r_tx_cnt == r_tx_div);
    case (r_tx_state)
      c_TX_IDLE:  if (!w_empty) begin w_tx_next = c_TX_START; w_pop = 1'b1; end
      c_TX_START: if (w_bit_done) w_tx_next = c_TX_DATA;
      c_TX_DATA:  if (w_bit_done && r_tx_bit == 3'd7) w_tx_next = c_TX_STOP;
      default: begin
        if (w_bit_done) begin
          if (!w_empty) begin w_tx_next = c_TX_START; w_pop = 1'b1; end
          else w_tx_next = c_TX_IDLE;
        end
      end
    endcase
  end

  // TX outputs decoded from the registered state, so tx changes only on clock edges.
  always_comb begin
    tx     = 1'b1;
    w_busy = (r_tx_state != c_TX_IDLE);
    case (r_tx_state)
      c_TX_START: tx = 1'b0;
      c_TX_DATA:  tx = r_tx_shift[0];
      default:    tx = 1'b1;
    endcase
  end

  // TX datapath: byte and divisor captured at pop; divisor stays fixed for the frame.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_tx_cnt <= '0; r_tx_div <= '0; r_tx_bit <= '0; r_tx_shift <= '0;
    end else if (w_pop) begin
      r_tx_shift <= r_mem[r_rptr];
      r_tx_div   <= r_div;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
    end else if (r_tx_state != c_TX_IDLE) begin
      if (w_bit_done) begin
        r_tx_cnt <= '0;
        if (r_tx_state == c_TX_DATA) begin
          r_tx_shift <= r_tx_shift >> 1;
          r_tx_bit   <= r_tx_bit + 3'd1;
        end
      end else r_tx_cnt <= r_tx_cnt + 16'd1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_apb_uart.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_apb_uart                                                  |
// | Description : Scoreboard bench for apb_uart; tx looped back to rx.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_apb_uart;
  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    logic        perr;
    string       name;
  } bus_exp_t;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         b2b;
  } tx_exp_t;

  logic pclk = 1'b0;
  logic rst;
  logic tx;
  logic rx;
  int   n_checks = 0;
  int   n_errors = 0;

  bus_exp_t bus_q[$];
  tx_exp_t  tx_q[$];
  logic [31:0] stat_mask;

  int         m_phase = -1;
  int         m_cyc = 0;
  bit         m_bad = 0;
  bit         m_pend = 0;
  tx_exp_t    m_cur;
  logic [7:0] m_got;
  logic       m_exp_bit;
  bus_exp_t   m_be;

  always #5 pclk = ~pclk;

  apb_uart_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_uart #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(16), .DEFAULT_DIV(16'd433)
  ) dut (
    .pclk(pclk), .rst(rst), .bus(bus), .tx(tx), .rx(rx)
  );

  assign rx = tx;

  // Monitor: bus responses popped on each ready pulse; tx frames checked cycle by cycle.
  always @(negedge pclk) begin
    if (!rst && bus.ready === 1'b1) begin
      n_checks++;
      if (bus_q.size() == 0) begin
        n_errors++;
        $display("FAIL bus_unexpected: ready pulse with prdata=%h perr=%b and nothing expected", bus.prdata, bus.perr);
      end else begin
        m_be = bus_q.pop_front();
        if (((bus.prdata & m_be.mask) !== (m_be.data & m_be.mask)) || bus.perr !== m_be.perr) begin
          n_errors++;
          $display("FAIL %s: got prdata=%h perr=%b, expected prdata=%h perr=%b (mask %h)",
                   m_be.name, bus.prdata, bus.perr, m_be.data, m_be.perr, m_be.mask);
        end
      end
    end
    if (rst) begin
      m_phase = -1;
      m_pend  = 0;
    end else begin
      if (m_phase == -2) begin
        if (tx === 1'b1) m_phase = -1;
      end else if (m_phase == -1) begin
        if (m_pend) begin
          m_pend = 0;
          n_checks++;
          if (tx !== 1'b0) begin
            n_errors++;
            $display("FAIL tx_gap: got tx=%b after stop bit, expected 0 (next start bit)", tx);
          end
        end
        if (tx === 1'b0) begin
          if (tx_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL tx_spurious: got start bit, expected idle line");
            m_phase = -2;
          end else begin
            m_cur   = tx_q.pop_front();
            m_phase = 0;
            m_cyc   = 0;
            m_bad   = 0;
            m_got   = 8'h00;
          end
        end
      end
      if (m_phase >= 0) begin
        if (m_phase == 0)      m_exp_bit = 1'b0;
        else if (m_phase == 9) m_exp_bit = 1'b1;
        else                   m_exp_bit = m_cur.data[m_phase-1];
        if (tx !== m_exp_bit) m_bad = 1;
        if (m_phase >= 1 && m_phase <= 8 && m_cyc == m_cur.div / 2) m_got[m_phase-1] = tx;
        m_cyc++;
        if (m_cyc == m_cur.div + 1) begin
          m_cyc = 0;
          m_phase++;
          if (m_phase == 10) begin
            n_checks++;
            if (m_bad) begin
              n_errors++;
              $display("FAIL tx_frame: got byte %h with wrong bit timing/level, expected byte %h at %0d cycles/bit",
                       m_got, m_cur.data, m_cur.div + 1);
            end
            m_phase = -1;
            m_pend  = (tx_q.size() > 0) && tx_q[0].b2b;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apb(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                     input bit wr, input logic [31:0] exp_data, input logic [31:0] exp_mask,
                     input bit exp_perr, input string name);
    bus_exp_t e;
    bit got;
    e.data = exp_data; e.mask = exp_mask; e.perr = exp_perr; e.name = name;
    bus_q.push_back(e);
    @(negedge pclk);
    bus.paddr = addr; bus.pdata = data; bus.pstb = strb; bus.pwrite = wr;
    bus.psel = 1'b1; bus.penable = 1'b0;
    @(negedge pclk);
    bus.penable = 1'b1;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge pclk);
      if (bus.ready === 1'b1) got = 1;
    end
    bus.psel = 1'b0; bus.penable = 1'b0;
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no ready pulse, expected one within 8 cycles", name);
      e = bus_q.pop_back();
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input bit exp_perr, input string name);
    apb(addr, data, strb, 1'b1, 32'h0, 32'hFFFF_FFFF, exp_perr, name);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_data, input logic [31:0] mask,
                    input bit exp_perr, input string name);
    apb(addr, 32'h0, 4'hF, 1'b0, exp_data, mask, exp_perr, name);
  endtask

  task automatic expect_tx(input logic [7:0] data, input int div, input bit b2b);
    tx_exp_t t;
    t.data = data; t.div = div; t.b2b = b2b;
    tx_q.push_back(t);
  endtask

  task automatic wait_tx_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((tx_q.size() > 0 || m_phase != -1) && n < budget) begin
      @(negedge pclk);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got %0d frames still pending after %0d cycles, expected 0", name, tx_q.size(), budget);
      tx_q.delete();
    end
  endtask

  initial begin
    int n;
    bus.paddr = '0; bus.pdata = '0; bus.pstb = '0; bus.pwrite = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0;
    rst = 1'b1;
`ifdef UART_RX_EN
    stat_mask = 32'hFFFF_FFC7;
`else
    stat_mask = 32'hFFFF_FFFF;
`endif
    repeat (3) @(negedge pclk);
    chk("reset_ready", {31'b0, bus.ready}, 32'h0);
    chk("reset_perr", {31'b0, bus.perr}, 32'h0);
    chk("reset_prdata", bus.prdata, 32'h0);
    chk("reset_tx", {31'b0, tx}, 32'h1);
    rst = 1'b0;

    rd(32'h8, 32'h0000_01B1, 32'hFFFF_FFFF, 1'b0, "div_reset");
    rd(32'h4, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, "stat_reset");
    wr(32'h8, 32'h0000_0003, 4'b0011, 1'b0, "div_wr3");
    rd(32'h8, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0, "div_rd3");

    // 0x55 at 4 cycles/bit; tx falls the cycle after the ready pulse.
    expect_tx(8'h55, 3, 0);
    wr(32'h0, 32'h0000_0055, 4'b0001, 1'b0, "data_55");
    chk("tx_idle_at_ready", {31'b0, tx}, 32'h1);
    @(negedge pclk);
    chk("tx_latency", {31'b0, tx}, 32'h0);
    wait_tx_idle(200, "wait_55");

    // Two queued bytes: second start bit immediately after first stop bit.
    expect_tx(8'hA5, 3, 0);
    expect_tx(8'h0F, 3, 1);
    wr(32'h0, 32'h0000_00A5, 4'b0001, 1'b0, "data_a5");
    wr(32'h0, 32'h0000_000F, 4'b0001, 1'b0, "data_0f");
    wait_tx_idle(300, "wait_a5_0f");

    // Divisor change mid-frame applies only from the next frame.
    expect_tx(8'hC3, 3, 0);
    expect_tx(8'h81, 7, 1);
    wr(32'h0, 32'h0000_00C3, 4'b0001, 1'b0, "data_c3");
    wr(32'h0, 32'h0000_0081, 4'b0001, 1'b0, "data_81");
    wr(32'h8, 32'h0000_0007, 4'b0011, 1'b0, "div_wr7");
    wait_tx_idle(400, "wait_div_change");

    // Divisor byte enables.
    wr(32'h8, 32'hFFFF_FFFF, 4'b0001, 1'b0, "div_wr_lo");
    rd(32'h8, 32'h0000_00FF, 32'hFFFF_FFFF, 1'b0, "div_rd_lo");
    wr(32'h8, 32'h0000_0003, 4'b0011, 1'b0, "div_wr3b");

    // Unmapped register and a masked DATA write.
    rd(32'hC, 32'h0, 32'hFFFF_FFFF, 1'b1, "unmapped_rd");
    wr(32'hC, 32'h1234_5678, 4'hF, 1'b1, "unmapped_wr");
    wr(32'h0, 32'h0000_0077, 4'b0000, 1'b0, "data_nostrb");
    repeat (4) @(negedge pclk);
    rd(32'h4, 32'h0000_0002, stat_mask, 1'b0, "stat_no_push");
`ifdef UART_RX_EN
    rd(32'h0, 32'h0, 32'h0, 1'b0, "data_rd");
`else
    rd(32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1, "data_rd_norx");
`endif

    // Fill the FIFO behind a long frame: 16 accepted, 17th dropped with an error.
    wr(32'h8, 32'd39, 4'b0011, 1'b0, "div_wr39");
    expect_tx(8'h99, 39, 0);
    wr(32'h0, 32'h0000_0099, 4'b0001, 1'b0, "data_99");
    for (int i = 0; i < 17; i++) begin
      if (i < 16) expect_tx(8'h10 + 8'(i), 39, 1);
      wr(32'h0, 32'h10 + 32'(i), 4'b0001, (i == 16), (i == 16) ? "data_full_drop" : "data_fill");
    end
    rd(32'h4, 32'h0000_1005, stat_mask, 1'b0, "stat_full");
    wait_tx_idle(8000, "wait_fill");
    rd(32'h4, 32'h0000_0002, stat_mask, 1'b0, "stat_drained");

    // DIV=0: one cycle per bit.
    wr(32'h8, 32'h0, 4'b0011, 1'b0, "div_wr0");
    expect_tx(8'h6B, 0, 0);
    wr(32'h0, 32'h0000_006B, 4'b0001, 1'b0, "data_6b");
    wait_tx_idle(100, "wait_div0");

    // Reset during data bit 3: line returns high next cycle and the FIFO is flushed.
    wr(32'h8, 32'h3, 4'b0011, 1'b0, "div_wr3c");
    expect_tx(8'h00, 3, 0);
    wr(32'h0, 32'h0000_0000, 4'b0001, 1'b0, "data_00");
    wr(32'h0, 32'h0000_0012, 4'b0001, 1'b0, "data_12");
    n = 0;
    while (m_phase != 4 && n < 200) begin
      @(negedge pclk);
      n++;
    end
    chk("reach_bit3", {31'b0, (n < 200)}, 32'h1);
    rst = 1'b1;
    @(negedge pclk);
    chk("tx_after_rst", {31'b0, tx}, 32'h1);
    @(negedge pclk);
    rst = 1'b0;
    tx_q.delete();
    stat_mask = 32'hFFFF_FFFF;
    rd(32'h4, 32'h0000_0002, stat_mask, 1'b0, "stat_after_rst");
    rd(32'h8, 32'h0000_01B1, 32'hFFFF_FFFF, 1'b0, "div_after_rst");
    repeat (20) @(negedge pclk);

`ifdef UART_RX_EN
    // Loopback receive, then an unread byte overwritten by a second.
    wr(32'h8, 32'h3, 4'b0011, 1'b0, "div_wr3d");
    expect_tx(8'h3C, 3, 0);
    wr(32'h0, 32'h0000_003C, 4'b0001, 1'b0, "data_3c");
    wait_tx_idle(200, "wait_3c");
    repeat (10) @(negedge pclk);
    rd(32'h4, 32'h0000_000A, 32'hFFFF_FFFF, 1'b0, "stat_rx_valid");
    rd(32'h0, 32'h0000_003C, 32'hFFFF_FFFF, 1'b0, "rx_data_3c");
    rd(32'h4, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, "stat_rx_cleared");
    expect_tx(8'h11, 3, 0);
    expect_tx(8'h22, 3, 1);
    wr(32'h0, 32'h0000_0011, 4'b0001, 1'b0, "data_11");
    wr(32'h0, 32'h0000_0022, 4'b0001, 1'b0, "data_22");
    wait_tx_idle(300, "wait_11_22");
    repeat (10) @(negedge pclk);
    rd(32'h4, 32'h0000_001A, 32'hFFFF_FFFF, 1'b0, "stat_rx_ovr");
    rd(32'h0, 32'h0000_0022, 32'hFFFF_FFFF, 1'b0, "rx_data_22");
    wr(32'h4, 32'h0000_0030, 4'b0001, 1'b0, "stat_clear");
    rd(32'h4, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, "stat_flags_clr");
    rd(32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, "rx_data_empty");
`endif

    repeat (5) @(negedge pclk);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'h0);
    chk("tx_queue_drained", 32'(tx_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
